// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the 7-segment capture path.
// Segment order is {a,b,c,d,e,f,g}, with a in bit 6 and 1 meaning lit.
package seg7_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] bcd_t;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } frame_state_t;

    localparam seg7_t SEG_ZERO  = 7'b1111110;
    localparam seg7_t SEG_ONE   = 7'b0110000;
    localparam seg7_t SEG_TWO   = 7'b1101101;
    localparam seg7_t SEG_THREE = 7'b1111001;
    localparam seg7_t SEG_FOUR  = 7'b0110011;
    localparam seg7_t SEG_FIVE  = 7'b1011011;
    localparam seg7_t SEG_SIX   = 7'b1011111;
    localparam seg7_t SEG_SEVEN = 7'b1110000;
    localparam seg7_t SEG_EIGHT = 7'b1111111;
    localparam seg7_t SEG_NINE  = 7'b1111011;

    localparam bcd_t BCD_INVALID = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment to BCD decoder; unknown patterns map to
// BCD_INVALID with the invalid flag raised.
module seg7_decode
    import seg7_pkg::*;
(
    input  seg7_t seg,
    output bcd_t  bcd,
    output logic  invalid
);

    // Pattern lookup against the ten legal digit shapes
    always_comb begin
        bcd     = BCD_INVALID;
        invalid = 1'b1;
        case (seg)
            SEG_ZERO:  begin bcd = 4'd0; invalid = 1'b0; end
            SEG_ONE:   begin bcd = 4'd1; invalid = 1'b0; end
            SEG_TWO:   begin bcd = 4'd2; invalid = 1'b0; end
            SEG_THREE: begin bcd = 4'd3; invalid = 1'b0; end
            SEG_FOUR:  begin bcd = 4'd4; invalid = 1'b0; end
            SEG_FIVE:  begin bcd = 4'd5; invalid = 1'b0; end
            SEG_SIX:   begin bcd = 4'd6; invalid = 1'b0; end
            SEG_SEVEN: begin bcd = 4'd7; invalid = 1'b0; end
            SEG_EIGHT: begin bcd = 4'd8; invalid = 1'b0; end
            SEG_NINE:  begin bcd = 4'd9; invalid = 1'b0; end
            default:   begin bcd = BCD_INVALID; invalid = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reader end of a multiplexed 7-segment display: debounces each digit,
// decodes it back to BCD and hands complete frames out over valid/ready.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    frame_ready,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    overrun
);

    localparam int SAMPLE_W = 7 + NUM_DIGITS;
    localparam int RUN_W    = $clog2(STABLE_CYCLES + 1);

    localparam logic [RUN_W-1:0]      RUN_ZERO = RUN_W'(0);
    localparam logic [RUN_W-1:0]      RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0]      RUN_MAX  = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0]      RUN_PRE  = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ZERO = NUM_DIGITS'(0);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);

    logic [SAMPLE_W-1:0]     sample_s;
    logic [SAMPLE_W-1:0]     sample_r;
    logic [RUN_W-1:0]        run_r;
    logic [RUN_W-1:0]        run_next_s;
    logic                    onehot_s;
    logic                    same_s;
    logic                    capture_s;
    logic [NUM_DIGITS-1:0]   mask_r;
    logic [NUM_DIGITS-1:0]   mask_next_s;
    logic [4*NUM_DIGITS-1:0] slot_r;
    logic [NUM_DIGITS-1:0]   err_r;
    bcd_t                    dec_bcd_s;
    logic                    dec_inv_s;
    frame_state_t            state_r;
    frame_state_t            state_next_s;
    logic                    complete_s;
    logic                    load_s;
    logic                    drop_s;
    logic                    clear_mask_s;

    seg7_decode u_decode (
        .seg     (seg_in),
        .bcd     (dec_bcd_s),
        .invalid (dec_inv_s)
    );

    assign sample_s   = {seg_in, dig_sel};
    assign onehot_s   = (dig_sel != DIG_ZERO) && ((dig_sel & (dig_sel - DIG_ONE)) == DIG_ZERO);
    assign same_s     = (sample_s == sample_r);
    assign complete_s = &mask_r;

    // Stability run length; capture fires only on the cycle the run first hits the target
    always_comb begin
        run_next_s = RUN_ZERO;
        capture_s  = 1'b0;
        if (!onehot_s) begin
            run_next_s = RUN_ZERO;
            capture_s  = 1'b0;
        end else if (same_s) begin
            if (run_r == RUN_MAX) begin
                run_next_s = RUN_MAX;
            end else begin
                run_next_s = run_r + RUN_ONE;
            end
            capture_s = (run_r == RUN_PRE);
        end else begin
            run_next_s = RUN_ONE;
            capture_s  = (STABLE_CYCLES == 1);
        end
    end

    // Frame hand-off decisions from the completed mask and consumer backpressure
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        drop_s       = 1'b0;
        clear_mask_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (complete_s) begin
                    load_s       = 1'b1;
                    clear_mask_s = 1'b1;
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (complete_s) begin
                    clear_mask_s = 1'b1;
                    load_s       = frame_ready;
                    drop_s       = !frame_ready;
                    state_next_s = ST_FULL;
                end else if (frame_ready) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // A capture in the hand-off cycle starts the next frame, so it survives the clear
    always_comb begin
        mask_next_s = clear_mask_s ? DIG_ZERO : mask_r;
        if (capture_s) begin
            mask_next_s = mask_next_s | dig_sel;
        end else begin
            mask_next_s = mask_next_s;
        end
    end

    // Sample history, run counter, capture mask and per-digit slots
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_r <= {SAMPLE_W{1'b0}};
            run_r    <= RUN_ZERO;
            mask_r   <= DIG_ZERO;
            slot_r   <= {(4*NUM_DIGITS){1'b0}};
            err_r    <= DIG_ZERO;
        end else begin
            sample_r <= sample_s;
            run_r    <= run_next_s;
            mask_r   <= mask_next_s;
            if (capture_s) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (dig_sel[i]) begin
                        slot_r[4*i +: 4] <= dec_bcd_s;
                        err_r[i]         <= dec_inv_s;
                    end
                end
            end
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered frame outputs; held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_bcd   <= {(4*NUM_DIGITS){1'b0}};
            frame_err   <= DIG_ZERO;
            overrun     <= 1'b0;
        end else begin
            frame_valid <= (state_next_s == ST_FULL);
            overrun     <= drop_s;
            if (load_s) begin
                frame_bcd <= slot_r;
                frame_err <= err_r;
            end
        end
    end

endmodule
